lifo_stack_v2: RTL

//  Parametrised LIFO: generalised depth/width with derived pointer width, a registered top-of-stack

---
 rtl/stack_pkg.sv | 24 ++
 rtl/stack_mem.sv | 27 ++
 rtl/lifo_stack_v2.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared types and helpers for the parametrised LIFO stack.
package stack_pkg;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_PUSH,
        OP_POP,
        OP_REPL
    } stack_op_e;

    // Bits needed to hold any value in 0..value-1; never less than 1.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        if (bits < 1) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Storage array for the LIFO stack: one synchronous write port, one asynchronous read port.
module stack_mem
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = 2,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lifo_stack_v2.sv
// Parametrised LIFO with registered top-of-stack, replace operation, occupancy thresholds
// and sticky overflow/underflow flags.
module lifo_stack_v2
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = 2,
    parameter int DEPTH      = 16,
    parameter int AF_MARGIN  = 2,
    parameter int AE_MARGIN  = 2,
    localparam int CNT_W     = clog2(DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CLEAR,
    input  logic                  PUSH,
    input  logic                  POP,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    output logic [DATA_WIDTH-1:0] TOP,
    output logic [DATA_WIDTH-1:0] POP_DATA,
    output logic                  POP_VALID,
    output logic [CNT_W-1:0]      COUNT,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(DEPTH - AF_MARGIN);
    localparam logic [CNT_W-1:0] AE_LEVEL = CNT_W'(AE_MARGIN);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

    stack_op_e             op;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH-1:0] top;
    logic [DATA_WIDTH-1:0] pop_data;
    logic                  pop_valid;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  wr_en;
    logic [CNT_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      rd_ptr;
    logic [DATA_WIDTH-1:0] rd_data;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    always_comb begin
        op = OP_NOP;
        case ({PUSH, POP})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = OP_REPL;
            default: op = OP_NOP;
        endcase
    end

    // A replace overwrites the current top slot; on an empty stack it degenerates to a push at 0.
    always_comb begin
        wr_en  = 1'b0;
        wr_ptr = count;
        if (!RST && !CLEAR) begin
            if (op == OP_PUSH && !full) begin
                wr_en = 1'b1;
            end else if (op == OP_REPL) begin
                wr_en = 1'b1;
                if (!empty) begin
                    wr_ptr = count - ONE;
                end
            end
        end
        rd_ptr = (count >= TWO) ? (count - TWO) : '0;
    end

    stack_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk     (CLK),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (DATA_IN),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            count     <= '0;
            top       <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (CLEAR) begin
            count     <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pop_valid <= 1'b0;
            case (op)
                OP_PUSH: begin
                    if (!full) begin
                        count <= count + ONE;
                        top   <= DATA_IN;
                    end else begin
                        overflow <= 1'b1;
                    end
                end
                OP_POP: begin
                    if (!empty) begin
                        pop_data  <= top;
                        pop_valid <= 1'b1;
                        count     <= count - ONE;
                        if (count >= TWO) begin
                            top <= rd_data;
                        end
                    end else begin
                        underflow <= 1'b1;
                    end
                end
                OP_REPL: begin
                    top <= DATA_IN;
                    if (!empty) begin
                        pop_data  <= top;
                        pop_valid <= 1'b1;
                    end else begin
                        count     <= ONE;
                        underflow <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign TOP          = top;
    assign POP_DATA     = pop_data;
    assign POP_VALID    = pop_valid;
    assign COUNT        = count;
    assign FULL         = full;
    assign EMPTY        = empty;
    assign ALMOST_FULL  = (count >= AF_LEVEL);
    assign ALMOST_EMPTY = (count <= AE_LEVEL);
    assign OVERFLOW     = overflow;
    assign UNDERFLOW    = underflow;

endmodule
